// File: rtl/spike_pkg.sv
// spike_pkg: shared definitions for the spike collector.
//   - Packet field bit positions for the 64-bit packet
//     {dest[63:60], src[59:56], type[55:54], zeros[53:10], addr[9:0]},
//     where addr = {X[9:5], Y[4:0]}.
//   - Packet type codes and the done code.
//   - Collector state enumeration.
package spike_pkg;

    localparam int DEST_HI = 63;
    localparam int DEST_LO = 60;
    localparam int SRC_HI  = 59;
    localparam int SRC_LO  = 56;
    localparam int TYPE_HI = 55;
    localparam int TYPE_LO = 54;
    localparam int ADDR_HI = 9;
    localparam int ADDR_LO = 0;
    localparam int X_HI    = 9;
    localparam int X_LO    = 5;
    localparam int Y_HI    = 4;
    localparam int Y_LO    = 0;

    localparam logic [1:0] OUT_SPIKE_TYPE = 2'b11;
    localparam logic [1:0] MEMBRANE_TYPE  = 2'b10;
    localparam logic [9:0] DONE_CODE      = 10'h3FF;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DRAIN    = 2'd1,
        FINISHED = 2'd2
    } collector_state_t;

endpackage

// File: rtl/spike_bitmap.sv
// spike_bitmap: ROWS x COLS array of single-bit flops holding the output
// spikes of one timestep.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears every bit)
//   setEn/setRow/setCol  set one bit (row, column)
//   clrEn/clrRow    clear one whole row
//   rdRow/rdData    combinational row read; rows at or beyond ROWS read as 0
// The owner never sets and clears the same row in one cycle: setting only
// happens while collecting and clearing only while draining.
module spike_bitmap #(
    parameter int ROWS = 21,
    parameter int COLS = 21
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            setEn,
    input  logic [4:0]      setRow,
    input  logic [4:0]      setCol,
    input  logic            clrEn,
    input  logic [4:0]      clrRow,
    input  logic [4:0]      rdRow,
    output logic [COLS-1:0] rdData
);

    logic [COLS-1:0] rowBits [ROWS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                rowBits[r] <= '0;
            end
        end else begin
            if (setEn) begin
                rowBits[setRow][setCol] <= 1'b1;
            end
            if (clrEn) begin
                rowBits[clrRow] <= '0;
            end
        end
    end

    // The read index runs one past the last row at the end of a drain.
    assign rdData = (rdRow < 5'(ROWS)) ? rowBits[rdRow] : '0;

endmodule

// File: rtl/spike_collector.sv
// spike_collector: collects output-spike packets from the partial-sum adders
// into a ROWS x COLS bitmap, and once NUM_ADDERS done packets have arrived
// drains the bitmap row by row to output memory, clearing it as it goes.
// After TIMESTEPS timesteps the block stops and raises all_done.
//
// Optional feature macro: SPIKE_COUNT_EN adds spike_cnt[8:0], the number of
// distinct spikes stored in the current timestep, valid while ts_done is high.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   packet input handshake, in_data = packet
//   out_valid/out_ready row output handshake, out_data = {row index, row bits}
//   ts_done             one-cycle pulse after the last row of a timestep
//   timestep            index of the timestep being collected
//   all_done            set after TIMESTEPS timesteps, held until reset
//   err                 sticky: a packet was dropped
//   spike_cnt           (SPIKE_COUNT_EN only) distinct spikes this timestep
//   dbgState            current collector state, for observation
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. Ready/valid driven by this block are flops decoded from the state
// only, never from the partner's valid/ready; out_data holds still while
// out_valid is high and out_ready is low.
module spike_collector
    import spike_pkg::*;
#(
    parameter int         WIDTH      = 64,
    parameter int         NUM_ADDERS = 5,
    parameter int         ROWS       = 21,
    parameter int         COLS       = 21,
    parameter int         TIMESTEPS  = 10,
    parameter logic [3:0] MY_ADDRESS = 4'b1010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5+COLS-1:0] out_data,
    output logic              ts_done,
    output logic [3:0]        timestep,
    output logic              all_done,
`ifdef SPIKE_COUNT_EN
    output logic [8:0]        spike_cnt,
`endif
    output logic              err,
    output logic [1:0]        dbgState
);

    localparam logic [4:0] ROWS_L   = 5'(ROWS);
    localparam logic [4:0] COLS_L   = 5'(COLS);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [2:0] ADDERS_L = 3'(NUM_ADDERS);
    localparam logic [3:0] TS_L     = 4'(TIMESTEPS);

    collector_state_t state;
    logic [2:0]       doneCnt;
    logic [4:0]       rowPtr;

    logic [3:0]       pktDest;
    logic [1:0]       pktType;
    logic [9:0]       pktAddr;
    logic [4:0]       pktX;
    logic [4:0]       pktY;
    logic             accept;
    logic             hdrOk;
    logic             isDone;
    logic             inRange;
    logic             doneAcc;
    logic             spikeAcc;
    logic             dropPkt;
    logic             lastDone;
    logic             outHs;
    logic [4:0]       rdRow;
    logic [COLS-1:0]  rdData;
    logic             unusedBits;

    assign pktDest = in_data[DEST_HI:DEST_LO];
    assign pktType = in_data[TYPE_HI:TYPE_LO];
    assign pktAddr = in_data[ADDR_HI:ADDR_LO];
    assign pktX    = in_data[X_HI:X_LO];
    assign pktY    = in_data[Y_HI:Y_LO];

    // Source and padding bits carry nothing the collector needs.
    assign unusedBits = ^{in_data[SRC_HI:SRC_LO], in_data[TYPE_LO-1:ADDR_HI+1]};

    assign accept   = in_valid && in_ready;
    assign hdrOk    = (pktDest == MY_ADDRESS) && (pktType == OUT_SPIKE_TYPE);
    assign isDone   = (pktAddr == DONE_CODE);
    assign inRange  = (pktX < ROWS_L) && (pktY < COLS_L);
    assign doneAcc  = accept && hdrOk && isDone;
    assign spikeAcc = accept && hdrOk && !isDone && inRange;
    assign dropPkt  = accept && !(hdrOk && (isDone || inRange));
    assign lastDone = doneAcc && ((doneCnt + 3'd1) == ADDERS_L);
    assign outHs    = out_valid && out_ready;

    // One read port serves three purposes: the row after the current one while
    // draining (preloaded into out_data on each handshake), row 0 when the
    // final done opens the drain, and the target row of a spike so a repeat
    // can be recognised.
    always_comb begin
        rdRow = pktX;
        if (state == DRAIN) begin
            rdRow = rowPtr + 5'd1;
        end else if (isDone) begin
            rdRow = 5'd0;
        end
    end

    spike_bitmap #(
        .ROWS(ROWS),
        .COLS(COLS)
    ) bitmap (
        .clk   (clk),
        .rst   (rst),
        .setEn (spikeAcc),
        .setRow(pktX),
        .setCol(pktY),
        .clrEn (outHs),
        .clrRow(rowPtr),
        .rdRow (rdRow),
        .rdData(rdData)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            ts_done   <= 1'b0;
            timestep  <= 4'd0;
            all_done  <= 1'b0;
            err       <= 1'b0;
            doneCnt   <= 3'd0;
            rowPtr    <= 5'd0;
        end else begin
            ts_done <= 1'b0;
            if (dropPkt) begin
                err <= 1'b1;
            end
            case (state)
                COLLECT: begin
                    if (lastDone) begin
                        doneCnt   <= 3'd0;
                        rowPtr    <= 5'd0;
                        state     <= DRAIN;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= {5'd0, rdData};
                    end else if (doneAcc && (doneCnt != ADDERS_L)) begin
                        doneCnt <= doneCnt + 3'd1;
                    end
                end
                DRAIN: begin
                    if (outHs) begin
                        if (rowPtr == LAST_ROW) begin
                            rowPtr    <= 5'd0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            ts_done   <= 1'b1;
                            timestep  <= timestep + 4'd1;
                            if ((timestep + 4'd1) == TS_L) begin
                                state    <= FINISHED;
                                all_done <= 1'b1;
                            end else begin
                                state    <= COLLECT;
                                in_ready <= 1'b1;
                            end
                        end else begin
                            rowPtr   <= rowPtr + 5'd1;
                            out_data <= {rowPtr + 5'd1, rdData};
                        end
                    end
                end
                FINISHED: begin
                    // Terminal until reset.
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

`ifdef SPIKE_COUNT_EN
    // A spike counts only if its bit was not already set this timestep.
    logic newSpike;
    assign newSpike = spikeAcc && !rdData[pktY];

    // The count is presented during the ts_done cycle and restarts at the
    // edge that ends it; a spike taken in that same cycle starts the new count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_cnt <= 9'd0;
        end else if (ts_done) begin
            spike_cnt <= {8'd0, newSpike};
        end else if (newSpike) begin
            spike_cnt <= spike_cnt + 9'd1;
        end
    end
`endif

    assign dbgState = state;

endmodule
